// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between a requester (master) and muldiv_seq (slave)
interface muldiv_seq_if;
  logic start, flush, busy, done, illegal;
  logic [2:0] op;
  logic [31:0] rs1, rs2, result;
  modport master (output start, op, rs1, rs2, flush, input busy, done, result, illegal);
  modport slave (input start, op, rs1, rs2, flush, output busy, done, result, illegal);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, one bit per cycle; define MULDIV_DIV_EN to build in the divider
module muldiv_seq #(
  parameter int ITER = 32
) (
  input logic clk,
  input logic rst,
  muldiv_seq_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, MUL = 3'd1, DIV = 3'd2, FIX = 3'd3, DONE = 3'd4;
  logic [2:0] state, op_q;
  logic [5:0] cnt;
  logic [31:0] b_mag, a_in, b_in, fix_val;
  logic [63:0] acc, acc_nx, prod;
  logic [32:0] mul_sum;
  logic neg, sa, sb, sgn_a, sgn_b, go, last, keep;
`ifdef MULDIV_DIV_EN
  logic rneg, special, ge;
  logic [32:0] trial;
  logic [31:0] diff, quo, rem;
`endif
  always_comb begin
    go = (state == IDLE || state == DONE) && bus.start && !bus.flush;
    sa = bus.op[2] ? !bus.op[0] : bus.op[1:0] != 2'b11;
    sb = bus.op[2] ? !bus.op[0] : !bus.op[1];
    sgn_a = bus.rs1[31] & sa;
    sgn_b = bus.rs2[31] & sb;
    a_in = sgn_a ? -bus.rs1 : bus.rs1;
    b_in = sgn_b ? -bus.rs2 : bus.rs2;
    last = cnt == 6'(ITER - 1);
    mul_sum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? b_mag : 32'd0};
    prod = neg ? -acc : acc;
`ifdef MULDIV_DIV_EN
    keep = 1'b0;
    special = bus.rs2 == 32'd0 || (sa && bus.rs1 == 32'h8000_0000 && bus.rs2 == 32'hFFFF_FFFF);
    trial = acc[63:31];
    ge = trial >= {1'b0, b_mag};
    diff = trial[31:0] - b_mag;
    acc_nx = state == DIV ? (ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0}) : {mul_sum, acc[31:1]};
    quo = neg ? -acc[31:0] : acc[31:0];
    rem = rneg ? -acc[63:32] : acc[63:32];
    fix_val = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
`else
    keep = op_q[2];
    acc_nx = {mul_sum, acc[31:1]};
    fix_val = op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32];
`endif
    bus.busy = state != IDLE;
    bus.done = state == DONE && !keep;
    bus.illegal = state == DONE && keep;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      cnt <= '0;
      b_mag <= '0;
      acc <= '0;
      neg <= 1'b0;
      bus.result <= '0;
`ifdef MULDIV_DIV_EN
      rneg <= 1'b0;
`endif
    end else if (go) begin
      op_q <= bus.op;
      cnt <= '0;
      b_mag <= b_in;
      acc <= {32'd0, a_in};
      neg <= sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
      rneg <= sgn_a;
      state <= bus.op[2] ? (special ? FIX : DIV) : MUL;
      // special divides preload the final quotient/remainder so FIX passes them through unsigned
      if (bus.op[2] && special) begin
        acc <= bus.rs2 == 32'd0 ? {bus.rs1, 32'hFFFF_FFFF} : {32'd0, 32'h8000_0000};
        neg <= 1'b0;
        rneg <= 1'b0;
      end
`else
      state <= bus.op[2] ? FIX : MUL;
`endif
    end else if (bus.flush || state == DONE) begin
      state <= IDLE;
    end else if (state == MUL || state == DIV) begin
      cnt <= cnt + 6'd1;
      acc <= acc_nx;
      if (last) state <= FIX;
    end else if (state == FIX) begin
      state <= DONE;
      if (!keep) bus.result <= fix_val;
    end
  end
endmodule
